// File: rtl/cmd_regfile.sv
// cmd_regfile: configuration register bank fed by the command arbiter's
// address/data/strobe bus.
//
// Each stretched write strobe (sw_in for bytes, sw_in32 for words) is
// rising-edge detected, so it is taken exactly once however long it stays high.
// Byte writes land in an 8-bit register bank. Address 0x00 is the read-only ID.
// PULSE_ADDR is a self-clearing command register. Word writes land in a
// 32-bit bank.
//
// Ports:
//   clk          clock
//   reset        synchronous active-low reset
//   reset_cmd    upstream soft reset, active-high, same effect as reset
//   addr         register address, stable around a strobe
//   sw_in        8-bit write strobe (level)
//   sw_in32      32-bit write strobe (level)
//   data_in      write byte
//   data_in32    write word
//   cfg_flat     register contents, reg n at [8n+7:8n]
//   word_flat    word contents, word n at [32n+31:32n]
//   cmd_pulse    one-cycle command pulses written to PULSE_ADDR
//   rd_data      registered readback of reg[addr]
//   wr_ack       one-cycle pulse per cycle with an accepted write
//   wr_err       sticky out-of-range write flag
//   write_count  wrapping count of accepted writes
module cmd_regfile #(
  parameter int          NUM_REGS   = 16,
  parameter int          NUM_WORDS  = 4,
  parameter logic [7:0]  ID         = 8'hA5,
  parameter logic [7:0]  PULSE_ADDR = 8'h02
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_cmd,
  input  logic [7:0]              addr,
  input  logic                    sw_in,
  input  logic                    sw_in32,
  input  logic [7:0]              data_in,
  input  logic [31:0]             data_in32,
  output logic [NUM_REGS*8-1:0]   cfg_flat,
  output logic [NUM_WORDS*32-1:0] word_flat,
  output logic [7:0]              cmd_pulse,
  output logic [7:0]              rd_data,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [15:0]             write_count
);

  // Nine-bit bounds so NUM_REGS = 256 is representable.
  localparam logic [8:0] NREGS  = 9'(NUM_REGS);
  localparam logic [8:0] NWORDS = 9'(NUM_WORDS);

  logic        clear;
  logic        sw_prev;
  logic        sw32_prev;
  logic        byte_ev;
  logic        word_ev;
  logic [8:0]  addr_ext;
  logic        byte_in_range;
  logic        word_in_range;
  logic        is_pulse;
  logic        byte_ok;
  logic        byte_store;
  logic        byte_err;
  logic        word_ok;
  logic        word_err;
  logic [7:0]  rd_next;

  logic [7:0]  regs  [NUM_REGS];
  logic [31:0] words [NUM_WORDS];

  assign clear    = !reset || reset_cmd;
  assign addr_ext = {1'b0, addr};

  assign byte_ev = sw_in && !sw_prev;
  assign word_ev = sw_in32 && !sw32_prev;

  assign byte_in_range = addr_ext < NREGS;
  assign word_in_range = addr_ext < NWORDS;
  assign is_pulse      = addr == PULSE_ADDR;

  // The ID address and the pulse address are acknowledged but never stored,
  // so their storage slots stay zero.
  assign byte_ok    = byte_ev && (is_pulse || byte_in_range);
  assign byte_store = byte_ev && byte_in_range && !is_pulse && (addr != 8'h00);
  assign byte_err   = byte_ev && !byte_ok;
  assign word_ok    = word_ev && word_in_range;
  assign word_err   = word_ev && !word_in_range;

  // Edge-detect history resets high so a strobe that is already high when
  // clear releases is not taken as a fresh write.
  always_ff @(posedge clk) begin
    if (clear) begin
      sw_prev   <= 1'b1;
      sw32_prev <= 1'b1;
    end else begin
      sw_prev   <= sw_in;
      sw32_prev <= sw_in32;
    end
  end

  // Write stage: banks, pulse, ack, error and counter all update on the edge
  // that closes the event cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      for (int i = 0; i < NUM_WORDS; i++) words[i] <= 32'h0;
      cmd_pulse   <= 8'h00;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      write_count <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (byte_store && addr_ext == 9'(i)) regs[i] <= data_in;
      end
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (word_ok && addr_ext == 9'(i)) words[i] <= data_in32;
      end
      cmd_pulse   <= (byte_ok && is_pulse) ? data_in : 8'h00;
      wr_ack      <= byte_ok || word_ok;
      if (byte_err || word_err) wr_err <= 1'b1;
      write_count <= write_count + {15'd0, byte_ok} + {15'd0, word_ok};
    end
  end

  // Readback mux. Out-of-range addresses and the pulse slot read as zero.
  always_comb begin
    rd_next = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_ext == 9'(i)) rd_next = regs[i];
    end
    if (addr == 8'h00) rd_next = ID;
  end

  // Readback stage: one cycle behind the address.
  always_ff @(posedge clk) begin
    if (clear) rd_data <= 8'h00;
    else       rd_data <= rd_next;
  end

  always_comb begin
    cfg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) cfg_flat[8*i +: 8] = regs[i];
  end

  always_comb begin
    word_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) word_flat[32*i +: 32] = words[i];
  end

endmodule

// File: tb/tb_cmd_regfile.sv
// tb_cmd_regfile: directed bench for cmd_regfile with default parameters.
module tb_cmd_regfile;

  logic         clk;
  logic         reset;
  logic         reset_cmd;
  logic [7:0]   addr;
  logic         sw_in;
  logic         sw_in32;
  logic [7:0]   data_in;
  logic [31:0]  data_in32;
  logic [127:0] cfg_flat;
  logic [127:0] word_flat;
  logic [7:0]   cmd_pulse;
  logic [7:0]   rd_data;
  logic         wr_ack;
  logic         wr_err;
  logic [15:0]  write_count;

  int checks;
  int passed;

  cmd_regfile dut (
    .clk(clk),
    .reset(reset),
    .reset_cmd(reset_cmd),
    .addr(addr),
    .sw_in(sw_in),
    .sw_in32(sw_in32),
    .data_in(data_in),
    .data_in32(data_in32),
    .cfg_flat(cfg_flat),
    .word_flat(word_flat),
    .cmd_pulse(cmd_pulse),
    .rd_data(rd_data),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; reset_cmd = 1'b0; addr = 8'h00;
    sw_in = 1'b0; sw_in32 = 1'b0; data_in = 8'h00; data_in32 = 32'h0;
    tick(); tick(); tick();
    checks++;
    if (cfg_flat !== 128'h0) $display("FAIL reset_cfg got %h want 0", cfg_flat); else passed++;
    checks++;
    if (word_flat !== 128'h0) $display("FAIL reset_word got %h want 0", word_flat); else passed++;
    checks++;
    if ({cmd_pulse, rd_data, wr_ack, wr_err, write_count} !== 34'h0)
      $display("FAIL reset_ctrl got pulse=%h rd=%h ack=%b err=%b cnt=%h want all 0",
               cmd_pulse, rd_data, wr_ack, wr_err, write_count);
    else passed++;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (rd_data !== 8'hA5) $display("FAIL reset_id got %h want a5", rd_data); else passed++;
  endtask

  task automatic test_byte_write();
    int acks;
    acks = 0;
    addr = 8'h05; data_in = 8'h3C; sw_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ack === 1'b1) acks++;
    end
    sw_in = 1'b0;
    tick();
    if (wr_ack === 1'b1) acks++;
    checks++;
    if (cfg_flat[47:40] !== 8'h3C) $display("FAIL byte_reg5 got %h want 3c", cfg_flat[47:40]); else passed++;
    checks++;
    if (acks !== 1) $display("FAIL byte_ack_count got %0d want 1", acks); else passed++;
    checks++;
    if (write_count !== 16'd1) $display("FAIL byte_count got %h want 0001", write_count); else passed++;
    checks++;
    if (rd_data !== 8'h3C) $display("FAIL byte_readback got %h want 3c", rd_data); else passed++;
  endtask

  task automatic test_pulse();
    addr = 8'h02; data_in = 8'h81; sw_in = 1'b1;
    tick();
    checks++;
    if (cmd_pulse !== 8'h81) $display("FAIL pulse_high got %h want 81", cmd_pulse); else passed++;
    tick();
    checks++;
    if (cmd_pulse !== 8'h00) $display("FAIL pulse_clear got %h want 00", cmd_pulse); else passed++;
    tick();
    sw_in = 1'b0;
    tick();
    checks++;
    if (rd_data !== 8'h00) $display("FAIL pulse_readback got %h want 00", rd_data); else passed++;
    checks++;
    if (cfg_flat[23:16] !== 8'h00) $display("FAIL pulse_storage got %h want 00", cfg_flat[23:16]); else passed++;
    checks++;
    if (write_count !== 16'd2) $display("FAIL pulse_count got %h want 0002", write_count); else passed++;
  endtask

  task automatic test_errors_and_dual();
    int acks;
    do_reset();
    acks = 0;
    addr = 8'h10; data_in = 8'h77; sw_in = 1'b1;
    tick();
    if (wr_ack === 1'b1) acks++;
    checks++;
    if (wr_err !== 1'b1) $display("FAIL err_byte got %b want 1", wr_err); else passed++;
    tick();
    checks++;
    if (rd_data !== 8'h00) $display("FAIL err_readback got %h want 00", rd_data); else passed++;
    sw_in = 1'b0;
    tick();
    addr = 8'h04; data_in32 = 32'hDEADBEEF; sw_in32 = 1'b1;
    tick();
    if (wr_ack === 1'b1) acks++;
    tick();
    sw_in32 = 1'b0;
    tick();
    checks++;
    if (wr_err !== 1'b1) $display("FAIL err_sticky got %b want 1", wr_err); else passed++;
    checks++;
    if (write_count !== 16'd0) $display("FAIL err_count got %h want 0000", write_count); else passed++;
    checks++;
    if (acks !== 0) $display("FAIL err_acks got %0d want 0", acks); else passed++;
    checks++;
    if (word_flat !== 128'h0) $display("FAIL err_words got %h want 0", word_flat); else passed++;

    addr = 8'h02; data_in = 8'h01; data_in32 = 32'h12345678;
    sw_in = 1'b1; sw_in32 = 1'b1;
    tick();
    checks++;
    if (wr_ack !== 1'b1) $display("FAIL dual_ack got %b want 1", wr_ack); else passed++;
    checks++;
    if (cmd_pulse !== 8'h01) $display("FAIL dual_pulse got %h want 01", cmd_pulse); else passed++;
    checks++;
    if (word_flat[95:64] !== 32'h12345678) $display("FAIL dual_word got %h want 12345678", word_flat[95:64]); else passed++;
    checks++;
    if (write_count !== 16'd2) $display("FAIL dual_count got %h want 0002", write_count); else passed++;
    tick();
    checks++;
    if ({wr_ack, cmd_pulse} !== 9'h000) $display("FAIL dual_after got ack=%b pulse=%h want 0 00", wr_ack, cmd_pulse); else passed++;
    checks++;
    if (wr_err !== 1'b1) $display("FAIL dual_err got %b want 1", wr_err); else passed++;
    sw_in = 1'b0; sw_in32 = 1'b0;
    tick();
  endtask

  task automatic test_reset_cmd_mid_strobe();
    int acks;
    acks = 0;
    addr = 8'h07; data_in = 8'h55;
    sw_in = 1'b1; reset_cmd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_ack === 1'b1) acks++;
    end
    reset_cmd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_ack === 1'b1) acks++;
    end
    checks++;
    if (cfg_flat[63:56] !== 8'h00) $display("FAIL rcmd_reg7 got %h want 00", cfg_flat[63:56]); else passed++;
    checks++;
    if (wr_err !== 1'b0) $display("FAIL rcmd_err got %b want 0", wr_err); else passed++;
    checks++;
    if (acks !== 0) $display("FAIL rcmd_acks got %0d want 0", acks); else passed++;
    checks++;
    if (write_count !== 16'd0) $display("FAIL rcmd_count got %h want 0000", write_count); else passed++;
    checks++;
    if (word_flat !== 128'h0) $display("FAIL rcmd_words got %h want 0", word_flat); else passed++;
    sw_in = 1'b0;
    tick();
    sw_in = 1'b1;
    tick();
    checks++;
    if (cfg_flat[63:56] !== 8'h55) $display("FAIL rcmd_rewrite got %h want 55", cfg_flat[63:56]); else passed++;
    sw_in = 1'b0;
    tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    addr = 8'h01; data_in = 8'h11; data_in32 = 32'h22;
    // Dual events add two per strobe, keeping the run short.
    for (int i = 0; i < 32767; i++) begin
      sw_in = 1'b1; sw_in32 = 1'b1;
      tick();
      sw_in = 1'b0; sw_in32 = 1'b0;
      tick();
    end
    sw_in = 1'b1;
    tick();
    sw_in = 1'b0;
    tick();
    checks++;
    if (write_count !== 16'hFFFF) $display("FAIL wrap_full got %h want ffff", write_count); else passed++;
    sw_in = 1'b1;
    tick();
    sw_in = 1'b0;
    tick();
    checks++;
    if (write_count !== 16'h0000) $display("FAIL wrap_zero got %h want 0000", write_count); else passed++;
    checks++;
    if (wr_err !== 1'b0) $display("FAIL wrap_err got %b want 0", wr_err); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_byte_write();
    test_pulse();
    test_errors_and_dual();
    test_reset_cmd_mid_strobe();
    test_count_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
